// File: rtl/filt_boxcar_sched.sv
// filt_boxcar_sched: round-robin shared boxcar averager for NUM_CH streams.
// Ports: clk, rst (sync, high), flush; in_valid/in_data/in_ready per
// channel; out_valid strobe with out_ch, out_data, out_primed (registered).
module filt_boxcar_sched #(
   parameter int DATA_WIDTH = 16,
   parameter int AVG_DEPTH  = 3,
   parameter int NUM_CH     = 4,
   localparam int CH_BITS   = $clog2(NUM_CH),
   localparam int SUM_WIDTH = DATA_WIDTH + AVG_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [NUM_CH-1:0]            in_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]            in_ready,
   output logic                         out_valid,
   output logic [CH_BITS-1:0]           out_ch,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_primed
);

   localparam int AVG_LENGTH = 1 << AVG_DEPTH;
   localparam int FW = AVG_DEPTH + 1;

   typedef enum logic {S_IDLE, S_CALC} state_t;

   state_t state, state_nxt;

   logic [CH_BITS-1:0]    last_grant;
   logic [CH_BITS-1:0]    grant;
   logic [CH_BITS-1:0]    idx;
   logic [CH_BITS-1:0]    cur_ch;
   logic                  req_any;
   logic                  accept;
   logic                  do_calc;
   logic [DATA_WIDTH-1:0] grant_data;
   logic [DATA_WIDTH-1:0] cur_data;

   logic [SUM_WIDTH-1:0]  sum_q  [NUM_CH];
   logic [AVG_DEPTH-1:0]  wptr_q [NUM_CH];
   logic [FW-1:0]         fill_q [NUM_CH];
   logic [DATA_WIDTH-1:0] hist   [NUM_CH][AVG_LENGTH];

   logic                  full;
   logic [DATA_WIDTH-1:0] old_word;
   logic [SUM_WIDTH-1:0]  sum_nxt;
   logic [SUM_WIDTH-1:0]  sum_mag;
   logic [SUM_WIDTH-1:0]  avg_mag;
   logic [SUM_WIDTH-1:0]  avg_full;
   logic [FW-1:0]         fill_nxt;

   // Search upward from the channel after the last grant.
   always_comb begin
      req_any = 1'b0;
      grant   = last_grant;
      idx     = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = CH_BITS'((int'(last_grant) + k) % NUM_CH);
         if (!req_any && in_valid[idx]) begin
            req_any = 1'b1;
            grant   = idx;
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant == CH_BITS'(i)) begin
            grant_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign accept   = (state == S_IDLE) && req_any && !flush && !rst;
   assign in_ready = accept ? (NUM_CH'(1) << grant) : '0;
   assign do_calc  = (state == S_CALC) && !flush;

   // Stale history words are masked until the window has filled.
   always_comb begin
      full     = (fill_q[cur_ch] == FW'(AVG_LENGTH));
      old_word = full ? hist[cur_ch][wptr_q[cur_ch]] : '0;
      sum_nxt  = sum_q[cur_ch]
               + {{AVG_DEPTH{cur_data[DATA_WIDTH-1]}}, cur_data}
               - {{AVG_DEPTH{old_word[DATA_WIDTH-1]}}, old_word};
      fill_nxt = full ? fill_q[cur_ch] : fill_q[cur_ch] + FW'(1);
      // Divide the magnitude so negative sums round toward zero.
      sum_mag  = sum_nxt[SUM_WIDTH-1] ? -sum_nxt : sum_nxt;
      avg_mag  = sum_mag >> AVG_DEPTH;
      avg_full = sum_nxt[SUM_WIDTH-1] ? -avg_mag : avg_mag;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (accept) state_nxt = S_CALC;
         S_CALC: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) begin
            sum_q[c]  <= '0;
            wptr_q[c] <= '0;
            fill_q[c] <= '0;
         end
         last_grant <= CH_BITS'(NUM_CH - 1);
         cur_ch     <= '0;
         cur_data   <= '0;
         out_valid  <= 1'b0;
         out_ch     <= '0;
         out_data   <= '0;
         out_primed <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
               sum_q[c]  <= '0;
               wptr_q[c] <= '0;
               fill_q[c] <= '0;
            end
         end else if (accept) begin
            cur_ch     <= grant;
            cur_data   <= grant_data;
            last_grant <= grant;
         end else if (do_calc) begin
            sum_q[cur_ch]  <= sum_nxt;
            wptr_q[cur_ch] <= wptr_q[cur_ch] + AVG_DEPTH'(1);
            fill_q[cur_ch] <= fill_nxt;
            out_valid      <= 1'b1;
            out_ch         <= cur_ch;
            out_data       <= avg_full[DATA_WIDTH-1:0];
            out_primed     <= (fill_nxt == FW'(AVG_LENGTH));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_calc && !rst) begin
         hist[cur_ch][wptr_q[cur_ch]] <= cur_data;
      end
   end

endmodule

// File: tb/tb_filt_boxcar_sched.sv
// tb_filt_boxcar_sched: directed and random stimulus for filt_boxcar_sched
// checked every cycle against a queue-based moving-average model.
module tb_filt_boxcar_sched;

   localparam int DW = 16;
   localparam int AD = 3;
   localparam int NC = 4;
   localparam int CB = 2;
   localparam int AL = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic [NC-1:0]    in_valid = '0;
   logic [NC*DW-1:0] in_data = '0;
   logic [NC-1:0]    in_ready;
   logic             out_valid;
   logic [CB-1:0]    out_ch;
   logic [DW-1:0]    out_data;
   logic             out_primed;

   filt_boxcar_sched #(
      .DATA_WIDTH(DW),
      .AVG_DEPTH (AD),
      .NUM_CH    (NC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .out_data  (out_data),
      .out_primed(out_primed)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp,
                  $time);
      end
   endtask

   typedef struct {
      bit v;
      int ch;
      int data;
      int avg;
      bit primed;
   } ent_t;

   ent_t          p0 = '{default: 0};
   ent_t          p1 = '{default: 0};
   int            win [NC][$];
   int            last_g = NC - 1;
   int            h_ch = 0;
   int            h_avg = 0;
   bit            h_pr = 0;
   logic [NC-1:0] acc_mask = '0;

   // Model: accept seen in cycle T, window updated in T+1, shown in T+2.
   always @(negedge clk) begin : mon
      logic [NC-1:0]        er;
      logic [DW-1:0]        ea;
      logic signed [DW-1:0] sd;
      ent_t                 nw;
      int                   s;
      int                   i;
      if (p1.v) begin
         h_ch  = p1.ch;
         h_avg = p1.avg;
         h_pr  = p1.primed;
      end
      ea = 16'(h_avg);
      chk("out_valid", 32'(out_valid), 32'(p1.v));
      chk("out_ch", 32'(out_ch), 32'(h_ch));
      chk("out_data", 32'(out_data), 32'(ea));
      chk("out_primed", 32'(out_primed), 32'(h_pr));
      er = '0;
      nw = '{default: 0};
      if (!p0.v && !flush && !rst) begin
         for (int k = 1; k <= NC; k++) begin
            i = (last_g + k) % NC;
            if (er == '0 && in_valid[i]) er[i] = 1'b1;
         end
      end
      chk("in_ready", 32'(in_ready), 32'(er));
      acc_mask = in_ready & in_valid;
      if (rst || flush) begin
         for (int c = 0; c < NC; c++) win[c].delete();
         p0.v = 0;
         if (rst) begin
            last_g = NC - 1;
            h_ch   = 0;
            h_avg  = 0;
            h_pr   = 0;
         end
      end else if (p0.v) begin
         win[p0.ch].push_back(p0.data);
         if (win[p0.ch].size() > AL) void'(win[p0.ch].pop_front());
         s = 0;
         for (int j = 0; j < win[p0.ch].size(); j++) s += win[p0.ch][j];
         p0.avg    = s / AL;
         p0.primed = (win[p0.ch].size() == AL);
      end
      p1 = p0;
      if (er != '0) begin
         nw.v = 1;
         for (int c = 0; c < NC; c++) if (er[c]) nw.ch = c;
         sd      = in_data[nw.ch*DW +: DW];
         nw.data = int'(sd);
         last_g  = nw.ch;
      end
      p0 = nw;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int ch, input int val, input bit fl);
      int n;
      bit got;
      in_data[ch*DW +: DW] = 16'(val);
      in_valid[ch] = 1'b1;
      n = 0;
      got = 0;
      while (!got && n < 50) begin
         tick();
         n++;
         got = acc_mask[ch];
      end
      chk("accept_wait", 32'(got), 32'd1);
      in_valid[ch] = 1'b0;
      if (fl) begin
         flush = 1'b1;
         tick();
         flush = 1'b0;
      end
   endtask

   initial begin
      in_valid = '1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
      in_valid = '0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      repeat (8) send(0, 100, 0);
      repeat (8) send(0, 0, 0);
      repeat (8) send(1, -1, 0);
      repeat (8) send(2, -100, 0);
      repeat (8) send(0, 100, 0);
      send(0, 100, 1);
      send(0, 80, 0);
      repeat (3) tick();

      in_data = {16'd40, 16'd30, 16'(-20), 16'd10};
      in_valid = '1;
      repeat (40) tick();
      in_valid = '0;
      repeat (4) tick();

      for (int t = 0; t < 3000; t++) begin
         for (int c = 0; c < NC; c++) begin
            if (in_valid[c] && acc_mask[c]) begin
               in_valid[c] = 1'b0;
            end else if (!in_valid[c] && $urandom_range(0, 1) == 1) begin
               in_valid[c] = 1'b1;
               if ($urandom_range(0, 1) == 1)
                  in_data[c*DW +: DW] = 16'($urandom);
               else
                  in_data[c*DW +: DW] = 16'(int'($urandom_range(0, 400)) - 200);
            end
         end
         flush = ($urandom_range(0, 15) == 0);
         rst   = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      flush = 1'b0;
      in_valid = '0;
      repeat (5) tick();
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
